// File: rtl/adder_rr_scheduler_if.sv
// adder_rr_scheduler_if: requester, response and adder-side handshake bundle for the scheduler
interface adder_rr_scheduler_if #(parameter int width = 4, parameter int n_req = 3);
  logic [n_req-1:0] req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [n_req*width-1:0] req_a, req_b;
  logic [width:0] rsp_data, sum_data;
  logic [width-1:0] a_data, b_data;
  logic a_vld, b_vld, a_rdy, b_rdy, sum_vld, sum_rdy;
  modport master(
    input req_vld, req_a, req_b, rsp_rdy, a_rdy, b_rdy, sum_vld, sum_data,
    output req_rdy, rsp_vld, rsp_data, a_vld, b_vld, a_data, b_data, sum_rdy
  );
  modport slave(
    output req_vld, req_a, req_b, rsp_rdy, a_rdy, b_rdy, sum_vld, sum_data,
    input req_rdy, rsp_vld, rsp_data, a_vld, b_vld, a_data, b_data, sum_rdy
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin sharing of one flow-controlled adder with in-order tag routing of sums
module adder_rr_scheduler #(
  parameter int width = 4,
  parameter int n_req = 3,
  parameter int depth = 4
) (
  input logic clk,
  input logic rst,
  adder_rr_scheduler_if.master bus
);
  localparam int iw = $clog2(n_req);
  localparam int pw = depth > 1 ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nx;
  logic [iw-1:0] gnt, rr, pick, head;
  logic [iw-1:0] tags [depth];
  logic [pw-1:0] wp, rp;
  logic [cw-1:0] cnt;
  logic found, a_done, b_done, a_hs, b_hs, done, pop, empty;
  // first valid requester at or after the rr pointer, scanned cyclically
  always_comb begin
    pick = rr;
    found = 1'b0;
    for (int i = n_req - 1; i >= 0; i--) begin
      if (bus.req_vld[(int'(rr) + i) % n_req]) begin
        pick = iw'((int'(rr) + i) % n_req);
        found = 1'b1;
      end
    end
  end
  // issue handshakes, tag-routed response path and next state
  always_comb begin
    head = tags[rp];
    empty = cnt == '0;
    bus.a_vld = state == ISSUE && !a_done;
    bus.b_vld = state == ISSUE && !b_done;
    bus.a_data = bus.req_a[int'(gnt)*width +: width];
    bus.b_data = bus.req_b[int'(gnt)*width +: width];
    a_hs = bus.a_vld && bus.a_rdy;
    b_hs = bus.b_vld && bus.b_rdy;
    done = state == ISSUE && (a_done || a_hs) && (b_done || b_hs);
    bus.req_rdy = done ? n_req'(1) << gnt : '0;
    bus.rsp_vld = (!empty && bus.sum_vld) ? n_req'(1) << head : '0;
    bus.rsp_data = bus.sum_data;
    bus.sum_rdy = !empty && bus.rsp_rdy[head];
    pop = bus.sum_vld && bus.sum_rdy;
    state_nx = state == IDLE ? (found && cnt < cw'(depth) ? ISSUE : IDLE) : (done ? IDLE : ISSUE);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // grant, pair progress, rr pointer and tag FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      rr <= '0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && state_nx == ISSUE) begin
        gnt <= pick;
        a_done <= 1'b0;
        b_done <= 1'b0;
      end else if (state == ISSUE) begin
        a_done <= a_done || a_hs;
        b_done <= b_done || b_hs;
      end
      if (done) rr <= gnt == iw'(n_req - 1) ? '0 : gnt + 1'b1;
      if (done) wp <= wp == pw'(depth - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == pw'(depth - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + cw'(done) - cw'(pop);
    end
  end
  // tag storage needs no reset; occupancy is tracked by cnt
  always_ff @(posedge clk) begin
    if (done) tags[wp] <= gnt;
  end
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed checks of arbitration, stalls, backpressure, tag routing and reset
module tb_adder_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  adder_rr_scheduler_if #(.width(4), .n_req(3)) bus();
  adder_rr_scheduler #(.width(4), .n_req(3), .depth(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int a_cnt = 0;
  int gnt_log[$];
  int rsp_idx[$];
  int rsp_dat[$];
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  // behavioural adder: independent a/b queues paired in order
  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (bus.sum_vld && bus.sum_rdy) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (bus.a_vld && bus.a_rdy) qa.push_back(bus.a_data);
      if (bus.b_vld && bus.b_rdy) qb.push_back(bus.b_data);
    end
    bus.sum_vld <= qa.size() > 0 && qb.size() > 0;
    bus.sum_data <= (qa.size() > 0 && qb.size() > 0) ? {1'b0, qa[0]} + {1'b0, qb[0]} : 5'd0;
  end
  // record grants, delivered responses and a-stream handshakes
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (bus.req_rdy[i]) gnt_log.push_back(i);
        if (bus.rsp_vld[i] && bus.rsp_rdy[i]) begin
          rsp_idx.push_back(i);
          rsp_dat.push_back(int'(bus.rsp_data));
        end
      end
      if (bus.a_vld && bus.a_rdy) a_cnt++;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int at(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction
  function automatic int sum_of(input int i);
    return i == 0 ? 4 : (i == 1 ? 7 : 10);
  endfunction
  initial begin
    int g0, r0, a0, bad;
    int per[3];
    bus.req_vld = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_rdy = '0;
    bus.a_rdy = 1'b0;
    bus.b_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_rdy", bus.req_rdy, 0);
    check("rst_rsp_vld", bus.rsp_vld, 0);
    check("rst_a_vld", bus.a_vld, 0);
    check("rst_b_vld", bus.b_vld, 0);
    check("rst_sum_rdy", bus.sum_rdy, 0);
    rst = 1'b0;
    bus.a_rdy = 1'b1;
    bus.b_rdy = 1'b1;
    bus.rsp_rdy = 3'b111;
    // single requester 0 sends (3,4)
    g0 = gnt_log.size();
    r0 = rsp_idx.size();
    bus.req_a[3:0] = 4'd3;
    bus.req_b[3:0] = 4'd4;
    bus.req_vld = 3'b001;
    for (int k = 0; k < 20 && bus.req_rdy[0] !== 1'b1; k++) @(negedge clk);
    check("t1_req_rdy", bus.req_rdy, 3'b001);
    check("t1_a_data", bus.a_data, 3);
    check("t1_b_data", bus.b_data, 4);
    @(negedge clk);
    bus.req_vld = '0;
    check("t1_rsp_vld", bus.rsp_vld, 3'b001);
    check("t1_rsp_data", bus.rsp_data, 7);
    repeat (3) @(negedge clk);
    check("t1_one_grant", gnt_log.size() - g0, 1);
    check("t1_one_rsp", rsp_idx.size() - r0, 1);
    // all requesters continuously valid; rr pointer now at 1
    g0 = gnt_log.size();
    r0 = rsp_idx.size();
    bus.req_a = {4'd3, 4'd2, 4'd1};
    bus.req_b = {4'd7, 4'd5, 4'd3};
    bus.req_vld = 3'b111;
    for (int k = 0; k < 300 && gnt_log.size() - g0 < 30; k++) @(negedge clk);
    bus.req_vld = '0;
    repeat (10) @(negedge clk);
    check("t2_grants", gnt_log.size() - g0, 30);
    bad = 0;
    for (int j = 0; j < 30; j++) if (at(gnt_log, g0 + j) != (1 + j) % 3) bad++;
    check("t2_rr_order", bad, 0);
    check("t2_rsps", rsp_idx.size() - r0, 30);
    bad = 0;
    per = '{0, 0, 0};
    for (int j = 0; j < 30; j++) begin
      if (at(rsp_idx, r0 + j) != (1 + j) % 3) bad++;
      else begin
        per[(1 + j) % 3]++;
        if (at(rsp_dat, r0 + j) != sum_of((1 + j) % 3)) bad++;
      end
    end
    check("t2_rsp_route", bad, 0);
    check("t2_req0_count", per[0], 10);
    check("t2_req1_count", per[1], 10);
    check("t2_req2_count", per[2], 10);
    // adder stalls b while a is accepted; requester 1 sends (5,6)
    r0 = rsp_idx.size();
    a0 = a_cnt;
    bus.b_rdy = 1'b0;
    bus.req_a[7:4] = 4'd5;
    bus.req_b[7:4] = 4'd6;
    bus.req_vld = 3'b010;
    @(negedge clk);
    check("t3_a_vld_first", bus.a_vld, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_a_vld_drop", bus.a_vld, 0);
      check("t3_b_vld_hold", bus.b_vld, 1);
      check("t3_no_req_rdy", bus.req_rdy, 0);
    end
    bus.b_rdy = 1'b1;
    #1;
    check("t3_req_rdy", bus.req_rdy, 3'b010);
    @(negedge clk);
    bus.req_vld = '0;
    repeat (4) @(negedge clk);
    check("t3_single_a", a_cnt - a0, 1);
    check("t3_rsp_count", rsp_idx.size() - r0, 1);
    check("t3_rsp_idx", at(rsp_idx, r0), 1);
    check("t3_rsp_data", at(rsp_dat, r0), 11);
    // response backpressure fills the tag FIFO; rr pointer now at 2
    g0 = gnt_log.size();
    r0 = rsp_idx.size();
    bus.rsp_rdy = '0;
    bus.req_a = {4'd3, 4'd2, 4'd1};
    bus.req_b = {4'd7, 4'd5, 4'd3};
    bus.req_vld = 3'b111;
    repeat (40) @(negedge clk);
    check("t4_full_grants", gnt_log.size() - g0, 4);
    check("t4_sum_rdy", bus.sum_rdy, 0);
    check("t4_head_vld", bus.rsp_vld, 3'b100);
    bad = 0;
    if (at(gnt_log, g0) != 2) bad++;
    if (at(gnt_log, g0 + 1) != 0) bad++;
    if (at(gnt_log, g0 + 2) != 1) bad++;
    if (at(gnt_log, g0 + 3) != 2) bad++;
    check("t4_grant_order", bad, 0);
    bus.rsp_rdy = 3'b111;
    for (int k = 0; k < 100 && rsp_idx.size() - r0 < 4; k++) @(negedge clk);
    bad = 0;
    if (at(rsp_idx, r0) != 2 || at(rsp_dat, r0) != 10) bad++;
    if (at(rsp_idx, r0 + 1) != 0 || at(rsp_dat, r0 + 1) != 4) bad++;
    if (at(rsp_idx, r0 + 2) != 1 || at(rsp_dat, r0 + 2) != 7) bad++;
    if (at(rsp_idx, r0 + 3) != 2 || at(rsp_dat, r0 + 3) != 10) bad++;
    check("t4_drain_order", bad, 0);
    for (int k = 0; k < 100 && gnt_log.size() - g0 < 5; k++) @(negedge clk);
    check("t4_resume", int'(gnt_log.size() - g0 >= 5), 1);
    check("t4_resume_gnt", at(gnt_log, g0 + 4), 0);
    bus.req_vld = '0;
    repeat (10) @(negedge clk);
    // carry kept and tag routing: requester 2 sends (F,F)
    bus.rsp_rdy = '0;
    bus.req_a[11:8] = 4'hF;
    bus.req_b[11:8] = 4'hF;
    bus.req_vld = 3'b100;
    for (int k = 0; k < 20 && bus.req_rdy[2] !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    bus.req_vld = '0;
    for (int k = 0; k < 20 && bus.rsp_vld === 3'b000; k++) @(negedge clk);
    check("t5_rsp_vld", bus.rsp_vld, 3'b100);
    check("t5_rsp_data", bus.rsp_data, 5'h1E);
    check("t5_sum_rdy_lo", bus.sum_rdy, 0);
    bus.rsp_rdy = 3'b011;
    #1;
    check("t5_other_rdy", bus.sum_rdy, 0);
    bus.rsp_rdy = 3'b100;
    #1;
    check("t5_own_rdy", bus.sum_rdy, 1);
    @(negedge clk);
    check("t5_popped", bus.rsp_vld, 0);
    // reset in the middle of ISSUE, adder reset alongside
    bus.rsp_rdy = 3'b111;
    bus.b_rdy = 1'b0;
    bus.req_a[3:0] = 4'd1;
    bus.req_b[3:0] = 4'd1;
    bus.req_vld = 3'b001;
    for (int k = 0; k < 20 && bus.a_vld !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_req_rdy", bus.req_rdy, 0);
    check("t6_a_vld", bus.a_vld, 0);
    check("t6_b_vld", bus.b_vld, 0);
    check("t6_rsp_vld", bus.rsp_vld, 0);
    check("t6_sum_rdy", bus.sum_rdy, 0);
    rst = 1'b0;
    bus.req_vld = '0;
    bus.b_rdy = 1'b1;
    @(negedge clk);
    g0 = gnt_log.size();
    r0 = rsp_idx.size();
    bus.req_a[7:4] = 4'd2;
    bus.req_b[7:4] = 4'd2;
    bus.req_vld = 3'b010;
    for (int k = 0; k < 20 && bus.req_rdy[1] !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    bus.req_vld = '0;
    repeat (5) @(negedge clk);
    check("t6_grant_count", gnt_log.size() - g0, 1);
    check("t6_grant_idx", at(gnt_log, g0), 1);
    check("t6_rsp_count", rsp_idx.size() - r0, 1);
    check("t6_rsp_idx", at(rsp_idx, r0), 1);
    check("t6_rsp_data", at(rsp_dat, r0), 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
Shares one adder_with_flow_control instance between n_req requesters. Each requester presents an (a, b) operand pair with valid/ready. The block round-robin arbitrates between requesters, issues the winning pair on the adder's a and b streams, and records the winner's index in an in-order tag FIFO. It uses that tag to route each sum back to the requester that issued it. It sits between the requester fabric and the adder and keeps the adder's in-order pairing semantics intact.

Parameters:
width, 4, operand width; sum is width+1
n_req, 3, number of requesters (2..8)
depth, 4, tag FIFO depth = max pairs in flight inside the adder

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_vld  in  n_req  per-requester operand pair valid
req_rdy  out  n_req  per-requester operand pair accepted
req_a  in  n_req*width  packed a operands, requester i at [i*width +: width]
req_b  in  n_req*width  packed b operands, same packing
rsp_vld  out  n_req  per-requester sum valid
rsp_rdy  in  n_req  per-requester sum ready
rsp_data  out  width+1  sum, shared by all requesters
a_vld, b_vld  out  1  to adder
a_rdy, b_rdy  in  1  from adder
a_data, b_data  out  width  to adder
sum_vld  in  1  from adder
sum_rdy  out  1  to adder
sum_data  in  width+1  from adder

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset outputs: req_rdy=0, rsp_vld=0, a_vld=b_vld=0, sum_rdy=0. Internal reset values: FSM=IDLE, rr pointer=0, tag FIFO empty, a_done=b_done=0.
- FSM states:
  - IDLE: if any req_vld and tag count < depth, grant the first requester at or after the rr pointer (cyclic), latch its index as gnt, clear a_done and b_done, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE:
    - a_vld = ~a_done; b_vld = ~b_done; a_data/b_data are driven combinationally from req_a[gnt]/req_b[gnt].
    - An a handshake sets a_done; a b handshake sets b_done.
    - When both are complete (same cycle or earlier): req_rdy[gnt]=1 for exactly that cycle; push gnt into the tag FIFO; set rr pointer = (gnt+1) mod n_req; go to IDLE.
- Requesters must hold req_vld and their data stable until req_rdy. A request is consumed only when the whole pair has completed. Minimum issue latency is 1 cycle after req_vld; best-case throughput is one pair per 2 cycles.
- Only one requester is ever granted at a time. Once granted, a requester is not preempted.
- Response path is combinational. With tag FIFO non-empty, head = t:
  - rsp_vld[t] = sum_vld; all other rsp_vld bits = 0.
  - rsp_data = sum_data.
  - sum_rdy = rsp_rdy[t].
  - A sum handshake pops the tag.
- Tag FIFO empty: sum_rdy=0 and all rsp_vld=0. A sum_vld in this state is a protocol error and is never accepted.
- Tag FIFO full: no new grant. A pair already in ISSUE completes, because its slot was checked at grant time.
- Simultaneous push and pop on the FIFO are allowed; the count is unchanged. FIFO pointers wrap modulo depth.
- Sums are width+1 bits and carry is never lost: 4'hF + 4'hF = 5'h1E.
- Reset mid-operation aborts ISSUE and flushes all tags. The adder must be reset in the same cycle.

Test Plan:
- Single requester: req 0 sends (3,4) with rsp_rdy=1 -> a/b issued, rsp_vld[0] with rsp_data=5'h07, req_rdy[0] pulses once.
- All n_req=3 requesters valid continuously -> grants in order 0,1,2,0,1,2; each requester's rsp_data equals its own a+b; no starvation over 30 pairs.
- Adder stalls b (b_rdy=0 for 5 cycles) while a_rdy=1 -> a_vld drops after its handshake; b_vld stays high; req_rdy[gnt] only after b accepted; no duplicate a.
- rsp_rdy=0 on all requesters for 40 cycles -> exactly depth=4 pairs issued, then no grants. Releasing rsp_rdy -> 4 responses in issue order, then issuing resumes.
- Overflow and tag check: requester 2 sends (F,F) -> rsp_vld[2] only, rsp_data=5'h1E.
- rst asserted mid-ISSUE (with adder reset) -> next cycle all outputs at reset values and FIFO empty; a subsequent request from requester 1 is granted first only if rr pointer=0 and requester 0 is idle.
